dual_rail_linear_map: RTL
=========================

Name: dual_rail_linear_map

Overview:
- Parametrised, pipelined dual-rail GF(2) matrix map (out = M·in ⊕ C) for the masked/dual-rail S-box datapath.
- Generalises the fixed 8-bit field-isomorphism stage to a configurable width with two selectable matrix/constant sets (forward map, or inverse map plus affine).
- Adds a valid/ready handshake, enforced return-to-spacer between tokens, and codeword error detection.
- Sits between the byte-substitution input register and the GF((2^4)^2) inversion stages; a second instance handles the output-side mapping.

Parameters:
- WIDTH, 8, data width in bits; each bit is carried on a T rail and an F rail.
- PIPE_STAGES, 2, register stages from acceptance to output (minimum 1).
- MAT0, 64'hA0DEACAEC69E5243, mode-0 matrix, flattened: bits [i*WIDTH +: WIDTH] form row i (output bit i); bit j of a row selects input bit j. Default is DELTA.
- CONST0, 8'h00, mode-0 additive constant.
- MAT1, identity, mode-1 matrix; the top level overrides it with the inverse map.
- CONST1, 8'h00, mode-1 additive constant; the top level overrides it with 8'h63.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- in_valid, in, 1, input token present.
- in_ready, out, 1, block accepts the token this cycle.
- In_T, in, WIDTH, true rails.
- In_F, in, WIDTH, false rails.
- mode, in, 1, selects MAT0/CONST0 (0) or MAT1/CONST1 (1); sampled with the token.
- out_valid, out, 1, output token present.
- out_ready, in, 1, downstream accepts.
- Out_T, out, WIDTH, true rails.
- Out_F, out, WIDTH, false rails.
- err, out, 1, sticky codeword error.
- err_clr, in, 1, synchronous clear of err.

Behaviour:
- Rail encoding per bit: T/F = 10 means 1, 01 means 0, 00 means spacer, 11 is invalid.
- Reset (asynchronous): every pipeline register goes to spacer (all rails 0). out_valid=0, err=0, acc_q=0, in_ready=0 while rst_n is low. Tokens in flight are discarded.
- Acceptance occurs when in_valid & in_ready.
- in_ready = !stall & !acc_q.
  - stall = out_valid & !out_ready.
  - acc_q is set on acceptance, cleared on the next non-stalled cycle.
  - Result: at most one token every 2 cycles, so the pipeline always carries a spacer slot between consecutive tokens.
- Mapping is combinational before stage 1 and uses only the dual-rail XOR/XOR3 gate cells.
  - out_bit[i] = XOR over j of (M[i][j] & in[j]), then XOR C[i].
  - A constant of 1 is implemented as a T/F rail swap, with no gate.
  - Rows with zero selected inputs produce the constant directly (dual-rail 0 or 1, never spacer).
- mode is captured with the token and travels with it. A mode change never affects tokens in flight.
- Non-accepting cycles load spacer into stage 1.
- Each stage holds its payload plus a valid bit. When stall=1, all stages freeze; otherwise all shift each cycle.
- Latency: the token accepted at cycle t appears at the output at cycle t+PIPE_STAGES, with out_valid=1.
- Output side:
  - Out_T/Out_F equal spacer whenever out_valid=0.
  - The output holds the token while out_ready=0.
  - The cycle after the handshake, the output is spacer (out_valid=0).
- Codeword check, on acceptance:
  - Any input bit pair equal to 11 or 00 makes the token invalid.
  - An invalid token is consumed (in_ready behaves normally), not forwarded (a spacer slot is loaded), and err is set.
- err clearing: err_clr clears err the next cycle. If an error and err_clr occur in the same cycle, err stays 1 (set wins).
- in_valid=0 with non-spacer rails is not checked.

Optional Feature:
- Macro: DR_LINEAR_MAP_ERR_CNT_EN.
- When defined:
  - Adds output err_cnt [7:0]: counts invalid tokens and saturates at 8'hFF.
  - err_clr also zeroes err_cnt. When err_clr and an error coincide, err_cnt = 1.
  - Reset value is 0.
- When undefined: the port and counter are absent and the other behaviour is identical.

Test Plan:
- Mode 0, default params, one token each with a spacer between:
  - dual-rail 0x01 → 0x01.
  - 0x02 → 0x5F.
  - 0x80 → 0xFC.
  - 0x83 → 0xA2.
  - Each output has out_valid after exactly 2 cycles; Out_T = value, Out_F = ~value.
- Mode 1 with CONST1=8'h63, identity MAT1:
  - 0x00 → 0x63.
  - 0xFF → 0x9C.
  - Then mode toggled to 0 while a token is in flight → the in-flight token still uses mode 1.
- Back-to-back in_valid=1 held for 6 cycles:
  - in_ready pattern is 1,0,1,0,1,0.
  - Three tokens are emitted, each followed by an all-zero spacer cycle.
- out_ready=0 for 5 cycles with a token at the output:
  - Out_T/Out_F and out_valid are held.
  - in_ready=0 throughout.
  - After out_ready=1, the next cycle shows spacer, and the queued tokens follow in order.
- Invalid inputs, one per accepted token:
  - Bit 3 presented as T=F=1 → err=1 and no out_valid for that slot.
  - Bit 5 presented as spacer (00) → err stays 1.
  - err_clr → err=0.
  - With the macro enabled, err_cnt reaches 2, then goes to 0.
- rst_n asserted asynchronously with 2 tokens in flight:
  - Outputs go to spacer immediately with out_valid=0.
  - After release, no stale tokens appear; the first new token has latency 2.

Source files
------------

// File: rtl/dual_rail_linear_map.sv
// Pipelined dual-rail GF(2) linear map (out = M*in ^ C) with valid/ready handshake and codeword check.
// Optional macro DR_LINEAR_MAP_ERR_CNT_EN adds an 8-bit saturating invalid-token counter on err_cnt.
module dual_rail_linear_map #(
    parameter int                     WIDTH       = 8,
    parameter int                     PIPE_STAGES = 2,
    parameter logic [WIDTH*WIDTH-1:0] MAT0        = 64'hA0DEACAEC69E5243,
    parameter logic [WIDTH-1:0]       CONST0      = 8'h00,
    parameter logic [WIDTH*WIDTH-1:0] MAT1        = 64'h8040201008040201,
    parameter logic [WIDTH-1:0]       CONST1      = 8'h00
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] In_T,
    input  logic [WIDTH-1:0] In_F,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out_T,
    output logic [WIDTH-1:0] Out_F,
    output logic             err,
`ifdef DR_LINEAR_MAP_ERR_CNT_EN
    output logic [7:0]       err_cnt,
`endif
    input  logic             err_clr
);

    // Dual-rail XOR cell, pairs are {T, F}; a spacer on either input yields a spacer.
    function automatic logic [1:0] dr_xor2(input logic [1:0] a, input logic [1:0] b);
        dr_xor2 = {(a[1] & b[0]) | (a[0] & b[1]), (a[1] & b[1]) | (a[0] & b[0])};
    endfunction

    function automatic logic dr_codeword_ok(input logic [WIDTH-1:0] t, input logic [WIDTH-1:0] f);
        dr_codeword_ok = &(t ^ f);
    endfunction

    // Returns {T rails, F rails}; a 1 in the constant swaps the rails of that output bit.
    function automatic logic [2*WIDTH-1:0] dr_map(input logic [WIDTH-1:0]       t,
                                                  input logic [WIDTH-1:0]       f,
                                                  input logic [WIDTH*WIDTH-1:0] m,
                                                  input logic [WIDTH-1:0]       c);
        logic [1:0]       acc;
        logic             have;
        logic [WIDTH-1:0] ot;
        logic [WIDTH-1:0] of;
        ot = '0;
        of = '0;
        for (int i = 0; i < WIDTH; i++) begin
            acc  = 2'b01;
            have = 1'b0;
            for (int j = 0; j < WIDTH; j++) begin
                if (m[i*WIDTH + j]) begin
                    acc  = have ? dr_xor2(acc, {t[j], f[j]}) : {t[j], f[j]};
                    have = 1'b1;
                end else begin
                    acc  = acc;
                end
            end
            acc   = c[i] ? {acc[0], acc[1]} : acc;
            ot[i] = acc[1];
            of[i] = acc[0];
        end
        dr_map = {ot, of};
    endfunction

    logic [WIDTH-1:0]   st_t_q [PIPE_STAGES];
    logic [WIDTH-1:0]   st_t_d [PIPE_STAGES];
    logic [WIDTH-1:0]   st_f_q [PIPE_STAGES];
    logic [WIDTH-1:0]   st_f_d [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] st_v_q;
    logic [PIPE_STAGES-1:0] st_v_d;
    logic               acc_q;
    logic               acc_d;
    logic               err_q;
    logic               err_d;
    logic               stall_s;
    logic               accept_s;
    logic               tok_ok_s;
    logic               bad_s;
    logic [2*WIDTH-1:0] map0_s;
    logic [2*WIDTH-1:0] map1_s;
    logic [2*WIDTH-1:0] map_s;

    assign stall_s  = out_valid & ~out_ready;
    assign in_ready = rst_n & ~stall_s & ~acc_q;
    assign accept_s = in_valid & in_ready;
    assign tok_ok_s = dr_codeword_ok(In_T, In_F);
    assign bad_s    = accept_s & ~tok_ok_s;
    assign map0_s   = dr_map(In_T, In_F, MAT0, CONST0);
    assign map1_s   = dr_map(In_T, In_F, MAT1, CONST1);
    assign map_s    = mode ? map1_s : map0_s;

    // Pipeline advance: stage 1 takes the mapped token or a spacer, all stages freeze on stall.
    always_comb begin
        st_t_d = st_t_q;
        st_f_d = st_f_q;
        st_v_d = st_v_q;
        if (!stall_s) begin
            if (accept_s && tok_ok_s) begin
                st_t_d[0] = map_s[2*WIDTH-1:WIDTH];
                st_f_d[0] = map_s[WIDTH-1:0];
                st_v_d[0] = 1'b1;
            end else begin
                st_t_d[0] = '0;
                st_f_d[0] = '0;
                st_v_d[0] = 1'b0;
            end
            for (int s = 1; s < PIPE_STAGES; s++) begin
                st_t_d[s] = st_t_q[s-1];
                st_f_d[s] = st_f_q[s-1];
                st_v_d[s] = st_v_q[s-1];
            end
        end else begin
            st_v_d = st_v_q;
        end
    end

    // Acceptance throttle and sticky error flag (a new error beats a clear).
    always_comb begin
        acc_d = acc_q;
        err_d = err_q;
        if (accept_s) begin
            acc_d = 1'b1;
        end else if (!stall_s) begin
            acc_d = 1'b0;
        end else begin
            acc_d = acc_q;
        end
        if (bad_s) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // State registers; reset fills every stage with spacer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < PIPE_STAGES; s++) begin
                st_t_q[s] <= '0;
                st_f_q[s] <= '0;
            end
            st_v_q <= '0;
            acc_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            st_t_q <= st_t_d;
            st_f_q <= st_f_d;
            st_v_q <= st_v_d;
            acc_q  <= acc_d;
            err_q  <= err_d;
        end
    end

    assign out_valid = st_v_q[PIPE_STAGES-1];
    assign Out_T     = st_t_q[PIPE_STAGES-1];
    assign Out_F     = st_f_q[PIPE_STAGES-1];
    assign err       = err_q;

`ifdef DR_LINEAR_MAP_ERR_CNT_EN
    logic [7:0] err_cnt_q;
    logic [7:0] err_cnt_d;

    // Saturating count of rejected tokens; a coincident error survives the clear as 1.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = bad_s ? 8'd1 : 8'd0;
        end else if (bad_s && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule
